// File: rtl/ro_puf_evaluator.sv
// Ring-oscillator PUF race evaluator: syncs two RO outputs, counts edges to terminal or timeout.
// Latency: RO edge to counter increment 3 clk; done pulses on the clock that ends the race.
// Backpressure: none; start is taken only in IDLE/DONE, and is ignored while busy.

// Brings one free-running oscillator output into the clk domain and flags its rising edges.
module ro_puf_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ro,
  output logic rise
);

  logic [1:0] sync;
  logic       prev;

  // Two-flop synchronizer, previous-value register, and a registered rising-edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], ro};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
    end
  end

endmodule

module ro_puf_evaluator #(
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic             tie,
  output logic             timeout,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] TERMINAL    = '1;
  localparam int               TMR_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYC);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             rise_a, rise_b;
  logic             run_q;
  logic [7:0]       settle_cnt;
  logic [TMR_W-1:0] tmr;

  logic             accept;
  logic             finish;
  logic             inc_a, inc_b;
  logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;
  logic             term_a, term_b;
  logic [TMR_W-1:0] tmr_nxt;
  logic             tmr_hit;

  ro_puf_edge_sync u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_a),
    .rise  (rise_a)
  );

  ro_puf_edge_sync u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_b),
    .rise  (rise_b)
  );

  // The oscillators run exactly while an evaluation is in flight.
  assign ro_en = run_q;
  assign busy  = run_q;

  // Race arithmetic: saturating counters, terminal detection and the timeout timer.
  always_comb begin
    inc_a     = (state == COUNT) && rise_a && (cnt_a != TERMINAL);
    inc_b     = (state == COUNT) && rise_b && (cnt_b != TERMINAL);
    cnt_a_nxt = cnt_a + {{(CNT_W-1){1'b0}}, inc_a};
    cnt_b_nxt = cnt_b + {{(CNT_W-1){1'b0}}, inc_b};
    term_a    = (cnt_a_nxt == TERMINAL);
    term_b    = (cnt_b_nxt == TERMINAL);
    tmr_nxt   = tmr + TMR_W'(1);
    tmr_hit   = (tmr_nxt == TMR_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the accept/finish strobes that steer the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (term_a || term_b || tmr_hit) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: clear on accepted start, count during COUNT, latch the verdict when the race ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      done       <= 1'b0;
      resp       <= 1'b0;
      tie        <= 1'b0;
      timeout    <= 1'b0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      settle_cnt <= 8'd0;
      tmr        <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        run_q      <= 1'b1;
        resp       <= 1'b0;
        tie        <= 1'b0;
        timeout    <= 1'b0;
        cnt_a      <= '0;
        cnt_b      <= '0;
        settle_cnt <= 8'd0;
        tmr        <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end else if (state == COUNT) begin
        cnt_a <= cnt_a_nxt;
        cnt_b <= cnt_b_nxt;
        tmr   <= tmr_nxt;
        if (finish) begin
          run_q <= 1'b0;
          // A terminal count decides the race even if the timer expires on the same clock.
          if (term_a || term_b) begin
            tie  <= term_a & term_b;
            resp <= term_a & ~term_b;
          end else begin
            timeout <= 1'b1;
            resp    <= (cnt_a_nxt > cnt_b_nxt);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ro_puf_evaluator.sv
module tb_ro_puf_evaluator;

  localparam int CNT_W  = 4;
  localparam int SETTLE = 4;
  localparam int TMO    = 200;
  localparam int TERM   = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             ro_a = 1'b0;
  logic             ro_b = 1'b0;
  logic             ro_en, busy, done, resp, tie, timeout;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  int half_a = 0, off_a = 0, half_b = 0, off_b = 0;
  int k = 0;
  bit tog_mode = 1'b0;

  typedef struct {
    string name;
    int ha, oa, hb, ob;
    int resp, tie, tmo, ca, cb;
  } vec_t;

  typedef struct {
    int resp, tie, tmo, ca, cb;
  } res_t;

  vec_t vecs[5];

  ro_puf_evaluator #(
    .CNT_W       (CNT_W),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ro_a    (ro_a),
    .ro_b    (ro_b),
    .ro_en   (ro_en),
    .busy    (busy),
    .done    (done),
    .resp    (resp),
    .tie     (tie),
    .timeout (timeout),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
  );

  always #5 clk = ~clk;

  // Oscillator level k negedges after enable: half==0 means stuck low; low before enable.
  function automatic bit lvl(input int h, input int o, input int p);
    if (h == 0 || p <= 0) return 1'b0;
    return (((p + o) / h) % 2) == 1;
  endfunction

  // Oscillator pair model, gated by ro_en and restarting from low on every enable.
  always @(negedge clk) begin
    if (tog_mode) begin
      ro_a = ~ro_a;
      ro_b = 1'($urandom_range(0, 1));
    end else if (ro_en) begin
      k = k + 1;
      ro_a = lvl(half_a, off_a, k);
      ro_b = lvl(half_b, off_b, k);
    end else begin
      k = 0;
      ro_a = 1'b0;
      ro_b = 1'b0;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // Reference: a rising level seen at posedge p is counted at posedge p+3 if that posedge
  // lies in the counting window (posedges SETTLE+1 .. SETTLE+TMO); first to TERM wins.
  function automatic res_t model(input int ha, input int oa, input int hb, input int ob);
    res_t r;
    int ca, cb;
    r = '{default: 0};
    ca = 0;
    cb = 0;
    for (int t = SETTLE + 1; t <= SETTLE + TMO; t++) begin
      if (lvl(ha, oa, t - 3) && !lvl(ha, oa, t - 4)) ca++;
      if (lvl(hb, ob, t - 3) && !lvl(hb, ob, t - 4)) cb++;
      if (ca == TERM || cb == TERM) begin
        r.tie  = (ca == TERM && cb == TERM) ? 1 : 0;
        r.resp = (ca == TERM && cb != TERM) ? 1 : 0;
        r.ca = ca; r.cb = cb;
        return r;
      end
      if (t == SETTLE + TMO) begin
        r.tmo  = 1;
        r.resp = (ca > cb) ? 1 : 0;
        r.ca = ca; r.cb = cb;
        return r;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, int'(ok), 1);
  endtask

  task automatic set_osc(input int ha, input int oa, input int hb, input int ob);
    half_a = ha; off_a = oa; half_b = hb; off_b = ob;
  endtask

  task automatic chk_result(input string name, input int r, input int t, input int to,
                            input int ca, input int cb);
    chk({name, "_resp"}, int'(resp), r);
    chk({name, "_tie"}, int'(tie), t);
    chk({name, "_timeout"}, int'(timeout), to);
    chk({name, "_cnt_a"}, int'(cnt_a), ca);
    chk({name, "_cnt_b"}, int'(cnt_b), cb);
  endtask

  // Full evaluation from IDLE/DONE, then verify a single done pulse and a quiet, held result.
  task automatic run_eval(input string name, input int r, input int t, input int to,
                          input int ca, input int cb);
    int d0;
    d0 = done_cnt;
    pulse_start();
    chk({name, "_busy"}, int'(busy), 1);
    chk({name, "_ro_en"}, int'(ro_en), 1);
    wait_done(name);
    chk_result(name, r, t, to, ca, cb);
    repeat (3) tick();
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    chk({name, "_ro_en_after"}, int'(ro_en), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_cnt_a_held"}, int'(cnt_a), ca);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int ha, hb, oa, ob;

    vecs[0] = '{"a_wins",   3, 0, 5, 0, 1, 0, 0, 15, 9};
    vecs[1] = '{"tie",      4, 0, 4, 0, 0, 1, 0, 15, 15};
    vecs[2] = '{"timeout",  10, 0, 0, 0, 1, 0, 1, 10, 0};
    vecs[3] = '{"b_wins",   5, 0, 3, 0, 0, 0, 0, 9, 15};
    vecs[4] = '{"tmo_eq",   0, 0, 0, 0, 0, 0, 1, 0, 0};

    // Reset held with activity on every input.
    tog_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start = ~start;
      tick();
    end
    start = 1'b0;
    chk("rst_ro_en", int'(ro_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_result("rst", 0, 0, 0, 0, 0);
    tog_mode = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed vectors.
    foreach (vecs[i]) begin
      set_osc(vecs[i].ha, vecs[i].oa, vecs[i].hb, vecs[i].ob);
      run_eval(vecs[i].name, vecs[i].resp, vecs[i].tie, vecs[i].tmo, vecs[i].ca, vecs[i].cb);
      repeat (2) tick();
    end

    // start pulses during SETTLE and COUNT must not disturb the race.
    begin
      int d0;
      set_osc(3, 0, 5, 0);
      d0 = done_cnt;
      pulse_start();
      tick();
      pulse_start();
      repeat (20) tick();
      chk("ign_busy_mid", int'(busy), 1);
      pulse_start();
      wait_done("ign");
      chk_result("ign", 1, 0, 0, 15, 9);
      repeat (3) tick();
      chk("ign_done_pulses", done_cnt - d0, 1);
    end

    // Asynchronous reset mid-COUNT.
    set_osc(3, 0, 5, 0);
    pulse_start();
    repeat (40) tick();
    chk("mid_cnt_nonzero", int'(cnt_a != 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ro_en", int'(ro_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt_a", int'(cnt_a), 0);
    chk("mid_rst_cnt_b", int'(cnt_b), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_eval("post_rst", 1, 0, 0, 15, 9);

    // Back-to-back: restart in the DONE cycle with B faster.
    set_osc(3, 0, 5, 0);
    pulse_start();
    wait_done("b2b_first");
    chk_result("b2b_first", 1, 0, 0, 15, 9);
    set_osc(5, 0, 3, 0);
    pulse_start();
    chk_result("b2b_clear", 0, 0, 0, 0, 0);
    chk("b2b_busy", int'(busy), 1);
    wait_done("b2b_second");
    chk_result("b2b_second", 0, 0, 0, 9, 15);
    repeat (3) tick();

    // Randomized races against the reference model.
    for (int n = 0; n < 16; n++) begin
      ha = $urandom_range(0, 12);
      hb = $urandom_range(0, 12);
      if (ha == 1) ha = 2;
      if (hb == 1) hb = 2;
      oa = (ha > 0) ? $urandom_range(0, ha - 1) : 0;
      ob = (hb > 0) ? $urandom_range(0, hb - 1) : 0;
      e = model(ha, oa, hb, ob);
      set_osc(ha, oa, hb, ob);
      run_eval($sformatf("rnd%0d", n), e.resp, e.tie, e.tmo, e.ca, e.cb);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
